// File: rtl/core.sv
// Shared core types for the target predictor feedback path.
package core;

    localparam int unsigned PC_W = 32;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] base_pc;
        logic [PC_W-1:0] targ_pc;
    } targ_pred_fb_t;

    localparam targ_pred_fb_t targ_pred_fb_rst = '0;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] base_pc;
        logic [PC_W-1:0] targ_pc;
    } targ_res_t;

endpackage

// File: rtl/targ_fb_alloc.sv
// Combinational lane allocator: decides per-lane accept, slot offset and drop count
// from lane valids, free slots and (optionally) coalescing match vectors.
module targ_fb_alloc #(
    parameter int unsigned res_ports = 3,
    parameter int unsigned depth     = 8
) (
    input  logic [res_ports-1:0]                       lane_valid,
    input  logic [$clog2(depth):0]                     free_slots,
    input  logic [res_ports-1:0]                       res_hit,
    input  logic [res_ports-1:0][res_ports-1:0]        lane_eq,
    output logic [res_ports-1:0]                       accept_c,
    output logic [res_ports-1:0][$clog2(depth)-1:0]    slot_off_c,
    output logic [$clog2(depth):0]                     acc_cnt_c,
    output logic [$clog2(depth):0]                     drop_inc_c
);

    localparam int unsigned PW = $clog2(depth);
    localparam int unsigned CW = PW + 1;

    logic [res_ports-1:0]          acc_v;
    logic [res_ports-1:0][PW-1:0]  off_v;
    logic [CW-1:0]                 n_acc;
    logic [CW-1:0]                 n_drop;
    logic                          skip;

    // Ascending lane walk; a lane is skipped if it duplicates a resident or an already-accepted lower lane.
    always_comb begin
        acc_v  = '0;
        off_v  = '0;
        n_acc  = '0;
        n_drop = '0;
        skip   = 1'b0;
        for (int i = 0; i < res_ports; i++) begin
            skip = res_hit[i];
            for (int j = 0; j < res_ports; j++) begin
                if (j < i && lane_eq[i][j] && acc_v[j]) begin
                    skip = 1'b1;
                end
            end
            if (lane_valid[i] && !skip) begin
                if (n_acc < free_slots) begin
                    acc_v[i] = 1'b1;
                    off_v[i] = PW'(n_acc);
                    n_acc    = n_acc + CW'(1);
                end else begin
                    n_drop = n_drop + CW'(1);
                end
            end
        end
    end

    assign accept_c   = acc_v;
    assign slot_off_c = off_v;
    assign acc_cnt_c  = n_acc;
    assign drop_inc_c = n_drop;

endmodule

// File: rtl/targ_fb_queue.sv
// In-order feedback FIFO between execute resolve lanes and the target predictor.
// Optional duplicate coalescing is enabled with `define TARG_FB_COALESCE_EN.
module targ_fb_queue
    import core::*;
#(
    parameter int unsigned res_ports  = 3,
    parameter int unsigned depth      = 8,
    parameter int unsigned drop_cnt_w = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [res_ports-1:0]             res_valid,
    input  logic [res_ports-1:0][PC_W-1:0]   res_base_pc,
    input  logic [res_ports-1:0][PC_W-1:0]   res_targ_pc,
    output logic                             in_ready,
    output targ_pred_fb_t                    targ_pred_fb,
    output logic [$clog2(depth):0]           occupancy,
    output logic [drop_cnt_w-1:0]            drop_cnt
);

    localparam int unsigned PW  = $clog2(depth);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned DW1 = drop_cnt_w + 1;

    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    targ_pred_fb_t          fb_q, fb_d;
    logic [drop_cnt_w-1:0]  drop_q, drop_d;
    logic [PC_W-1:0]        base_mem_q [depth];
    logic [PC_W-1:0]        base_mem_d [depth];
    logic [PC_W-1:0]        targ_mem_q [depth];
    logic [PC_W-1:0]        targ_mem_d [depth];

    targ_res_t                         lane [res_ports];
    logic [res_ports-1:0]              lane_valid;
    logic                              pop;
    logic [CW-1:0]                     free_slots;
    logic [res_ports-1:0]              res_hit;
    logic [res_ports-1:0][res_ports-1:0] lane_eq;
    logic [res_ports-1:0]              accept;
    logic [res_ports-1:0][PW-1:0]      slot_off;
    logic [CW-1:0]                     acc_cnt;
    logic [CW-1:0]                     drop_inc;
    logic [DW1-1:0]                    drop_sum;
    logic [PW-1:0]                     wr_idx;

    always_comb begin
        lane_valid = '0;
        for (int i = 0; i < res_ports; i++) begin
            lane[i] = '{valid: en & res_valid[i], base_pc: res_base_pc[i], targ_pc: res_targ_pc[i]};
            lane_valid[i] = lane[i].valid;
        end
    end

    // Popping first frees its slot for this cycle's pushes.
    assign pop        = en && (count_q != '0);
    assign free_slots = CW'(depth) - count_q + CW'(pop);

`ifdef TARG_FB_COALESCE_EN
    logic [PW-1:0] cmp_idx;

    // Residents are rd_ptr+m for m < count, minus the head when it leaves this cycle.
    always_comb begin
        res_hit = '0;
        lane_eq = '0;
        cmp_idx = '0;
        for (int i = 0; i < res_ports; i++) begin
            for (int j = 0; j < res_ports; j++) begin
                lane_eq[i][j] = (lane[i].base_pc == lane[j].base_pc) &&
                                (lane[i].targ_pc == lane[j].targ_pc);
            end
            for (int m = 0; m < depth; m++) begin
                cmp_idx = rd_ptr_q + PW'(m);
                if ((CW'(m) < count_q) && !(pop && (m == 0)) &&
                    (base_mem_q[cmp_idx] == lane[i].base_pc) &&
                    (targ_mem_q[cmp_idx] == lane[i].targ_pc)) begin
                    res_hit[i] = 1'b1;
                end
            end
        end
    end
`else
    assign res_hit = '0;
    assign lane_eq = '0;
`endif

    targ_fb_alloc #(
        .res_ports (res_ports),
        .depth     (depth)
    ) u_alloc (
        .lane_valid (lane_valid),
        .free_slots (free_slots),
        .res_hit    (res_hit),
        .lane_eq    (lane_eq),
        .accept_c   (accept),
        .slot_off_c (slot_off),
        .acc_cnt_c  (acc_cnt),
        .drop_inc_c (drop_inc)
    );

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(acc_cnt);
        count_d  = count_q - CW'(pop) + acc_cnt;

        fb_d = targ_pred_fb_rst;
        if (pop) begin
            fb_d = '{valid: 1'b1, base_pc: base_mem_q[rd_ptr_q], targ_pc: targ_mem_q[rd_ptr_q]};
        end

        // Saturate rather than wrap.
        drop_sum = {1'b0, drop_q} + DW1'(drop_inc);
        drop_d   = drop_sum[drop_cnt_w] ? '1 : drop_sum[drop_cnt_w-1:0];

        base_mem_d = base_mem_q;
        targ_mem_d = targ_mem_q;
        wr_idx     = '0;
        for (int i = 0; i < res_ports; i++) begin
            if (accept[i]) begin
                wr_idx             = wr_ptr_q + slot_off[i];
                base_mem_d[wr_idx] = lane[i].base_pc;
                targ_mem_d[wr_idx] = lane[i].targ_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            fb_q     <= targ_pred_fb_rst;
            drop_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            fb_q     <= fb_d;
            drop_q   <= drop_d;
        end
    end

    // Storage contents are don't-care after reset.
    always_ff @(posedge clk) begin
        base_mem_q <= base_mem_d;
        targ_mem_q <= targ_mem_d;
    end

    assign in_ready     = !rst && en &&
                          ((CW'(depth) - count_q + CW'(count_q != '0)) >= CW'(res_ports));
    assign targ_pred_fb = fb_q;
    assign occupancy    = count_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_targ_fb_queue.sv
// Scoreboard bench for targ_fb_queue: a count/drop model decides acceptance and
// queues expected feedback, which is compared as the DUT emits it.
module tb_targ_fb_queue;
    import core::*;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic [2:0]           res_valid;
    logic [2:0][31:0]     res_base_pc;
    logic [2:0][31:0]     res_targ_pc;
    logic                 in_ready;
    targ_pred_fb_t        fb;
    logic [3:0]           occupancy;
    logic [15:0]          drop_cnt;

    targ_fb_queue #(.res_ports(3), .depth(8), .drop_cnt_w(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .res_valid    (res_valid),
        .res_base_pc  (res_base_pc),
        .res_targ_pc  (res_targ_pc),
        .in_ready     (in_ready),
        .targ_pred_fb (fb),
        .occupancy    (occupancy),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk;
    int          n_err;
    int          m_cnt;
    logic        m_fbv;
    logic [15:0] m_drop;
    logic [63:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        logic [63:0] e;
        int          room;
        chk("fb_valid", 64'(fb.valid), 64'(m_fbv));
        if (m_fbv) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("fb_base", 64'(fb.base_pc), 64'(e[63:32]));
                chk("fb_targ", 64'(fb.targ_pc), 64'(e[31:0]));
            end
        end else begin
            chk("fb_base_idle", 64'(fb.base_pc), 64'(0));
            chk("fb_targ_idle", 64'(fb.targ_pc), 64'(0));
        end
        chk("occupancy", 64'(occupancy), 64'(m_cnt));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        room = 8 - m_cnt + ((m_cnt > 0) ? 1 : 0);
        chk("in_ready", 64'(in_ready), 64'(!rst && en && (room >= 3)));
    endtask

    // One cycle: check current outputs, drive new inputs, advance the model.
    task automatic cycle(input logic r, input logic e, input logic [2:0] v,
                         input logic [2:0][31:0] b, input logic [2:0][31:0] t);
        logic        pop;
        int          free;
        int          acc;
        logic        hit;
        logic [63:0] ent;
        @(negedge clk);
        check_outs();
        rst         = r;
        en          = e;
        res_valid   = v;
        res_base_pc = b;
        res_targ_pc = t;
        if (r) begin
            m_cnt  = 0;
            m_fbv  = 1'b0;
            m_drop = '0;
            sb.delete();
        end else begin
            pop  = e && (m_cnt > 0);
            free = 8 - m_cnt + (pop ? 1 : 0);
            acc  = 0;
            for (int i = 0; i < 3; i++) begin
                if (e && v[i]) begin
                    ent = {b[i], t[i]};
                    hit = 1'b0;
`ifdef TARG_FB_COALESCE_EN
                    for (int k = (pop ? 1 : 0); k < sb.size(); k++) begin
                        if (sb[k] == ent) hit = 1'b1;
                    end
`endif
                    if (!hit) begin
                        if (acc < free) begin
                            sb.push_back(ent);
                            acc++;
                        end else if (m_drop != 16'hFFFF) begin
                            m_drop++;
                        end
                    end
                end
            end
            m_cnt = m_cnt - (pop ? 1 : 0) + acc;
            m_fbv = pop;
        end
    endtask

    logic [2:0][31:0] zb;
    logic [2:0][31:0] b;
    logic [2:0][31:0] t;

    initial begin
        clk = 1'b0; rst = 1'b1; en = 1'b0;
        res_valid = '0; res_base_pc = '0; res_targ_pc = '0;
        n_chk = 0; n_err = 0; m_cnt = 0; m_fbv = 1'b0; m_drop = '0;
        zb = '0;

        repeat (2) cycle(1'b1, 1'b1, 3'b000, zb, zb);
        repeat (3) cycle(1'b0, 1'b1, 3'b000, zb, zb);

        // Single resolve on lane 1.
        b = '0; t = '0; b[1] = 32'h100; t[1] = 32'h200;
        cycle(1'b0, 1'b1, 3'b010, b, t);
        repeat (3) cycle(1'b0, 1'b1, 3'b000, zb, zb);

        // Four full-width bursts fill the queue and overflow.
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 3; i++) begin
                b[i] = 32'h1000 + 32'(16 * (3 * c + i));
                t[i] = 32'h8000 + 32'(16 * (3 * c + i));
            end
            cycle(1'b0, 1'b1, 3'b111, b, t);
        end
        @(posedge clk); #1;
        chk("burst_occ", 64'(occupancy), 64'(8));
        chk("burst_drop", 64'(drop_cnt), 64'(1));

        // Full queue plus two lanes: one accepted via the freed slot, one dropped.
        b[0] = 32'h2000; t[0] = 32'h9000; b[1] = 32'h2010; t[1] = 32'h9010;
        cycle(1'b0, 1'b1, 3'b011, b, t);
        @(posedge clk); #1;
        chk("full_occ", 64'(occupancy), 64'(8));
        chk("full_drop", 64'(drop_cnt), 64'(2));

        // Disabled: nothing moves.
        for (int i = 0; i < 3; i++) begin
            b[i] = 32'h3000 + 32'(4 * i); t[i] = 32'hA000 + 32'(4 * i);
        end
        repeat (4) cycle(1'b0, 1'b0, 3'b111, b, t);
        @(posedge clk); #1;
        chk("en_low_occ", 64'(occupancy), 64'(8));
        chk("en_low_fbv", 64'(fb.valid), 64'(0));
        repeat (10) cycle(1'b0, 1'b1, 3'b000, zb, zb);

        // Duplicate pair on lanes 0 and 2.
        b[0] = 32'h40; t[0] = 32'h80; b[1] = 32'h44; t[1] = 32'h88; b[2] = 32'h40; t[2] = 32'h80;
        cycle(1'b0, 1'b1, 3'b111, b, t);
        @(posedge clk); #1;
`ifdef TARG_FB_COALESCE_EN
        chk("coal_occ", 64'(occupancy), 64'(2));
`else
        chk("coal_occ", 64'(occupancy), 64'(3));
`endif
        chk("coal_drop", 64'(drop_cnt), 64'(2));
        repeat (5) cycle(1'b0, 1'b1, 3'b000, zb, zb);

        // Reset while holding entries.
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 3; i++) begin
                b[i] = 32'h5000 + 32'(16 * (3 * c + i)); t[i] = 32'hB000 + 32'(16 * (3 * c + i));
            end
            cycle(1'b0, 1'b1, 3'b111, b, t);
        end
        cycle(1'b1, 1'b1, 3'b111, b, t);
        repeat (5) cycle(1'b0, 1'b1, 3'b000, zb, zb);

        // Random traffic over a small PC set.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                b[i] = 32'h40 + 32'(4 * $urandom_range(0, 3));
                t[i] = 32'h80 + 32'(4 * $urandom_range(0, 3));
            end
            cycle(1'b0, ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), b, t);
        end
        repeat (10) cycle(1'b0, 1'b1, 3'b000, zb, zb);

        // Sustained overload drives the drop counter into saturation.
        for (int c = 0; c < 33000; c++) begin
            for (int i = 0; i < 3; i++) begin
                b[i] = 32'h10_0000 + 32'(16 * (3 * c + i));
                t[i] = 32'h80_0000 + 32'(16 * (3 * c + i));
            end
            cycle(1'b0, 1'b1, 3'b111, b, t);
        end
        @(posedge clk); #1;
        chk("drop_sat", 64'(drop_cnt), 64'(16'hFFFF));
        repeat (12) cycle(1'b0, 1'b1, 3'b000, zb, zb);
        @(negedge clk);
        check_outs();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
